// File: rtl/n64_vmux.sv
// N64 VI bus serialiser: one parallel pixel becomes SYNC/R/G/B cycles on D_o, one pixel per 4 VCLK.
// Optional: N64_VMUX_HOLD_LAST_EN repeats the previous pixel on underrun instead of blanking the colours.
module n64_vmux #(
  parameter int color_width = 7
) (
  input  logic                       VCLK,
  input  logic                       RST,
  input  logic [3*color_width+3:0]   pixel_i,
  input  logic                       pixel_valid_i,
  output logic                       pixel_ready_o,
  input  logic                       n16bit_mode_i,
  input  logic                       underrun_clr_i,
  output logic                       nDSYNC_o,
  output logic [color_width-1:0]     D_o,
  output logic                       underrun_o
);
  localparam int PW = 3*color_width+4;
  localparam int CW = color_width;

  logic [1:0]    phase_q;
  logic [PW-1:0] hold_q, cur_q;
  logic          hold_vld, mode_q;

  logic          load, accept, starve;
  logic [PW-1:0] fill, src;
  logic [CW-1:0] col, mask2, mask1;

  assign pixel_ready_o = !hold_vld | (phase_q == 2'd3);
  assign accept        = pixel_valid_i & pixel_ready_o;
  assign load          = (phase_q == 2'd3);
  assign starve        = load & !hold_vld & !accept;

`ifdef N64_VMUX_HOLD_LAST_EN
  assign fill = cur_q;
`else
  // Sync levels are held so the downstream timing stays intact; only colour is blanked.
  assign fill = {cur_q[PW-1 -: 4], {(3*CW){1'b0}}};
`endif

  always_comb begin
    src = fill;
    if (hold_vld)    src = hold_q;
    else if (accept) src = pixel_i;
  end

  // Reduced depth zeroes the LSBs the decoder later restores (5/6/5-style).
  assign mask2 = mode_q ? {CW{1'b1}} : {{(CW-2){1'b1}}, 2'b00};
  assign mask1 = mode_q ? {CW{1'b1}} : {{(CW-1){1'b1}}, 1'b0};

  always_comb begin
    col = '0;
    case (phase_q)
      2'd0:    col = cur_q[3*CW-1 -: CW] & mask2;
      2'd1:    col = cur_q[2*CW-1 -: CW] & mask1;
      2'd2:    col = cur_q[CW-1:0]       & mask2;
      default: col = '0;
    endcase
  end

  always_ff @(posedge VCLK) begin
    if (RST) begin
      phase_q    <= 2'd3;
      nDSYNC_o   <= 1'b1;
      D_o        <= '0;
      hold_vld   <= 1'b0;
      hold_q     <= '0;
      cur_q      <= '0;
      mode_q     <= 1'b1;
      underrun_o <= 1'b0;
    end else begin
      phase_q <= phase_q + 2'd1;
      if (load) begin
        cur_q    <= src;
        mode_q   <= n16bit_mode_i;
        hold_vld <= hold_vld & accept;
        if (hold_vld & accept) hold_q <= pixel_i;
        nDSYNC_o <= 1'b0;
        D_o      <= {{(CW-4){1'b0}}, src[PW-1 -: 4]};
      end else begin
        if (accept) begin
          hold_q   <= pixel_i;
          hold_vld <= 1'b1;
        end
        nDSYNC_o <= 1'b1;
        D_o      <= col;
      end
      if (starve)              underrun_o <= 1'b1;
      else if (underrun_clr_i) underrun_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_n64_vmux.sv
// Directed bench for n64_vmux: reset, colour depth, streaming, underrun and mid-pixel reset.
module tb_n64_vmux;
  localparam int CW = 7;
  localparam int PW = 3*CW+4;

  logic          VCLK = 1'b0;
  logic          RST;
  logic [PW-1:0] pixel_i;
  logic          pixel_valid_i, pixel_ready_o, n16bit_mode_i, underrun_clr_i;
  logic          nDSYNC_o, underrun_o;
  logic [CW-1:0] D_o;

  int n_cmp = 0;
  int n_bad = 0;

  n64_vmux #(.color_width(CW)) dut (
    .VCLK(VCLK), .RST(RST), .pixel_i(pixel_i), .pixel_valid_i(pixel_valid_i),
    .pixel_ready_o(pixel_ready_o), .n16bit_mode_i(n16bit_mode_i),
    .underrun_clr_i(underrun_clr_i), .nDSYNC_o(nDSYNC_o), .D_o(D_o),
    .underrun_o(underrun_o)
  );

  always #5 VCLK = ~VCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge VCLK);
    #1;
  endtask

  function automatic logic [PW-1:0] mk(input logic [3:0] s, input logic [CW-1:0] r,
                                       input logic [CW-1:0] g, input logic [CW-1:0] b);
    return {s, r, g, b};
  endfunction

  task automatic out(input string tag, input logic nd, input logic [CW-1:0] d);
    chk({tag, ".nd"}, 32'(nDSYNC_o), 32'(nd));
    chk({tag, ".d"},  32'(D_o),      32'(d));
  endtask

  logic [PW-1:0] strm [8];
  logic [CW-1:0] ucol;
  logic [CW-1:0] exp_d;
  int idx;
  logic acc;

  initial begin
    for (int k = 0; k < 8; k++)
      strm[k] = mk(4'(k+1), 7'(8'h10+k), 7'(8'h20+k), 7'(8'h40+k));
`ifdef N64_VMUX_HOLD_LAST_EN
    ucol = 7'h11;
`else
    ucol = 7'h00;
`endif

    RST = 1'b1; pixel_valid_i = 1'b0; pixel_i = '0; n16bit_mode_i = 1'b1; underrun_clr_i = 1'b0;
    repeat (3) tick();
    out("rst", 1'b1, 7'h00);
    chk("rst.rdy", 32'(pixel_ready_o), 32'd1);
    chk("rst.unr", 32'(underrun_o), 32'd0);

    // Full-depth pixel, bypass path on the first edge.
    RST = 1'b0; pixel_valid_i = 1'b1; pixel_i = mk(4'hF, 7'h55, 7'h2A, 7'h7F);
    tick(); out("a16.s", 1'b0, 7'h0F);
    n16bit_mode_i = 1'b0;
    tick(); out("a16.r", 1'b1, 7'h55);
    tick(); out("a16.g", 1'b1, 7'h2A);
    tick(); out("a16.b", 1'b1, 7'h7F);
    pixel_i = mk(4'hE, 7'h11, 7'h11, 7'h11);
    // Same pixel again from the hold register, reduced depth.
    tick(); out("a8.s", 1'b0, 7'h0F);
    tick(); out("a8.r", 1'b1, 7'h54);
    tick(); out("a8.g", 1'b1, 7'h2A);
    tick(); out("a8.b", 1'b1, 7'h7C);
    pixel_valid_i = 1'b0; n16bit_mode_i = 1'b1;
    tick(); out("e.s", 1'b0, 7'h0E);
    tick(); out("e.r", 1'b1, 7'h11);
    tick(); out("e.g", 1'b1, 7'h11);
    tick(); out("e.b", 1'b1, 7'h11);
    chk("e.unr", 32'(underrun_o), 32'd0);

    // Starved slot.
    tick(); out("u.s", 1'b0, 7'h0E); chk("u.unr", 32'(underrun_o), 32'd1);
    tick(); out("u.r", 1'b1, ucol);
    tick(); out("u.g", 1'b1, ucol);
    tick(); out("u.b", 1'b1, ucol);
    chk("u.sticky", 32'(underrun_o), 32'd1);
    underrun_clr_i = 1'b1;
    tick(); chk("u.setwins", 32'(underrun_o), 32'd1); out("u2.s", 1'b0, 7'h0E);
    tick(); chk("u.clr", 32'(underrun_o), 32'd0);
    underrun_clr_i = 1'b0;
    tick(); tick();

    // Eight back-to-back pixels.
    idx = 0; pixel_valid_i = 1'b1; pixel_i = strm[0];
    for (int j = 0; j < 32; j++) begin
      acc = pixel_valid_i & pixel_ready_o;
      tick();
      if (acc) idx++;
      if (idx < 8) pixel_i = strm[idx];
      else pixel_valid_i = 1'b0;
      case (j % 4)
        0:       exp_d = {3'b000, strm[j/4][PW-1 -: 4]};
        1:       exp_d = strm[j/4][3*CW-1 -: CW];
        2:       exp_d = strm[j/4][2*CW-1 -: CW];
        default: exp_d = strm[j/4][CW-1:0];
      endcase
      out($sformatf("st%0d", j), (j % 4) != 0, exp_d);
      chk($sformatf("st%0d.rdy", j), 32'(pixel_ready_o),
          32'((j == 0) || (j % 4 == 3) || (j >= 28)));
      chk($sformatf("st%0d.unr", j), 32'(underrun_o), 32'd0);
    end

    // Reset mid-pixel with a pixel waiting in the hold register.
    pixel_valid_i = 1'b1; pixel_i = mk(4'h3, 7'h33, 7'h33, 7'h33);
    tick(); out("q.s", 1'b0, 7'h03);
    pixel_i = mk(4'h5, 7'h5A, 7'h5A, 7'h5A);
    tick(); out("q.r", 1'b1, 7'h33);
    RST = 1'b1; pixel_valid_i = 1'b0;
    tick(); out("mr", 1'b1, 7'h00);
    chk("mr.rdy", 32'(pixel_ready_o), 32'd1);
    chk("mr.unr", 32'(underrun_o), 32'd0);
    RST = 1'b0;
    tick(); out("mr.s", 1'b0, 7'h00); chk("mr.unr2", 32'(underrun_o), 32'd1);
    tick(); out("mr.r", 1'b1, 7'h00);
    tick(); out("mr.g", 1'b1, 7'h00);
    tick(); out("mr.b", 1'b1, 7'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
